branch_predictor: RTL and testbench

Parametrised branch predictor for the pipelined MIPS core: a direct-mapped branch target buffer with per-entry saturating direction counters. It gives fetch a predicted next PC each cycle, trains on branches/jumps resolved in the memory stage, and produces the `btb_correct` / `btb_wrongtype` / redirect signals that the control unit's PC select consumes.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/branch_predictor_if.sv | 48 ++++
 rtl/bp_table.sv | 37 +++
 rtl/branch_predictor.sv | 109 ++++++++++
 tb/tb_branch_predictor.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch-predictor counter constants and helpers.
// Widths depend on the instantiating module, so the constants come from functions of CTR_W.
package cpu_types_pkg;

    localparam int BP_ENTRIES_DEF = 16;
    localparam int BP_CTR_W_DEF   = 2;

    // Weakly-taken is the midpoint 2^(w-1); weakly-not-taken sits one below it.
    function automatic int bp_ctr_weak(input int ctr_w, input bit taken);
        return taken ? (1 << (ctr_w - 1)) : ((1 << (ctr_w - 1)) - 1);
    endfunction

    typedef logic [BP_CTR_W_DEF-1:0] bp_ctr_t;

    localparam bp_ctr_t BP_CTR_WEAK_T  = bp_ctr_t'(bp_ctr_weak(BP_CTR_W_DEF, 1'b1));
    localparam bp_ctr_t BP_CTR_WEAK_NT = bp_ctr_t'(bp_ctr_weak(BP_CTR_W_DEF, 1'b0));

    // Entry layout: valid, tag = pc[31:IDX_W+2], target = pc[31:2], direction counter.
    typedef struct packed {
        logic                            valid;
        logic [31-$clog2(BP_ENTRIES_DEF)-2:0] tag;
        logic [29:0]                     target;
        bp_ctr_t                         ctr;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, memory-stage training and control outputs of the branch predictor.
// Perf counter signals exist only when BP_PERF_CNT_EN is defined.
interface branch_predictor_if;

    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_npc;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_npc;

    logic        btb_correct;
    logic        btb_wrongtype;
    logic [31:0] redirect_pc;

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_npc,
        input  pred_hit, pred_taken, pred_npc, btb_correct, btb_wrongtype, redirect_pc,
        input  perf_branches, perf_mispredicts
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_npc,
        output pred_hit, pred_taken, pred_npc, btb_correct, btb_wrongtype, redirect_pc,
        output perf_branches, perf_mispredicts
    );
`else
    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_npc,
        input  pred_hit, pred_taken, pred_npc, btb_correct, btb_wrongtype, redirect_pc
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_npc,
        output pred_hit, pred_taken, pred_npc, btb_correct, btb_wrongtype, redirect_pc
    );
`endif

endinterface

// File: rtl/bp_table.sv
// BTB entry storage: flop array with asynchronous reset, a lookup read port,
// a training read port and one write port. Reads are combinational (no bypass).
module bp_table #(
    parameter int                ENTRIES   = 16,
    parameter int                ENTRY_W   = 8,
    parameter logic [ENTRY_W-1:0] RST_ENTRY = '0,
    localparam int               IDX_W     = $clog2(ENTRIES)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [IDX_W-1:0]   lk_idx,
    output logic [ENTRY_W-1:0] lk_entry,
    input  logic [IDX_W-1:0]   tr_idx,
    output logic [ENTRY_W-1:0] tr_entry,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [ENTRY_W-1:0] wr_entry
);

    logic [ENTRY_W-1:0] mem [ENTRIES];

    // NOTE: this array is flops, not a RAM macro, so it takes the async reset;
    // every valid bit must clear immediately or stale entries would predict after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= RST_ENTRY;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign lk_entry = mem[lk_idx];
    assign tr_entry = mem[tr_idx];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: fetch lookup, memory-stage check and training.
// Optional feature: define BP_PERF_CNT_EN to add the branch / mispredict performance counters.
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEF,
    parameter int CTR_W   = BP_CTR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef logic [CTR_W-1:0] ctr_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [29:0]      target;
        ctr_t             ctr;
    } entry_t;

    localparam int     ENTRY_W   = $bits(entry_t);
    localparam ctr_t   CTR_WK_T  = ctr_t'(bp_ctr_weak(CTR_W, 1'b1));
    localparam ctr_t   CTR_WK_NT = ctr_t'(bp_ctr_weak(CTR_W, 1'b0));
    localparam ctr_t   CTR_MAX   = '1;
    localparam entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WK_NT};

    entry_t lk_e;
    entry_t tr_e;
    entry_t wr_e;
    logic   wr_en;
    logic   tr_hit;
    logic   mispredict;

    bp_table #(
        .ENTRIES  (ENTRIES),
        .ENTRY_W  (ENTRY_W),
        .RST_ENTRY(RST_ENTRY)
    ) u_table (
        .CLK     (CLK),
        .RST     (RST),
        .lk_idx  (bp.if_pc[IDX_W+1:2]),
        .lk_entry(lk_e),
        .tr_idx  (bp.upd_pc[IDX_W+1:2]),
        .tr_entry(tr_e),
        .wr_en   (wr_en),
        .wr_idx  (bp.upd_pc[IDX_W+1:2]),
        .wr_entry(wr_e)
    );

    // Reset holds every valid bit low, so the lookup needs no extra gating by RST.
    assign bp.pred_hit   = lk_e.valid && (lk_e.tag == bp.if_pc[31:IDX_W+2]);
    assign bp.pred_taken = bp.pred_hit && lk_e.ctr[CTR_W-1];
    assign bp.pred_npc   = bp.pred_taken ? {lk_e.target, 2'b00} : bp.if_pc + 32'd4;

    // A taken/taken pair still mispredicts when the carried target was stale.
    assign mispredict = bp.upd_valid &&
                        ((bp.upd_pred_taken != bp.upd_taken) ||
                         (bp.upd_taken && (bp.upd_pred_npc != bp.upd_target)));

    assign bp.btb_correct   = !mispredict;
    assign bp.btb_wrongtype = mispredict && !bp.upd_taken;
    assign bp.redirect_pc   = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;

    assign tr_hit = tr_e.valid && (tr_e.tag == bp.upd_pc[31:IDX_W+2]);

    // NOTE: combinational next-entry logic uses blocking assignments with a default
    // first, so every path assigns wr_en/wr_e and no latch is inferred.
    always_comb begin
        wr_en = 1'b0;
        wr_e  = tr_e;
        if (bp.upd_valid) begin
            if (tr_hit) begin
                wr_en = 1'b1;
                if (bp.upd_taken) begin
                    wr_e.target = bp.upd_target[31:2];
                    if (tr_e.ctr != CTR_MAX) wr_e.ctr = tr_e.ctr + ctr_t'(1);
                end else if (tr_e.ctr != '0) begin
                    wr_e.ctr = tr_e.ctr - ctr_t'(1);
                end
            end else if (bp.upd_taken) begin
                wr_en = 1'b1;
                wr_e  = '{valid: 1'b1, tag: bp.upd_pc[31:IDX_W+2],
                          target: bp.upd_target[31:2], ctr: CTR_WK_T};
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bp.perf_branches    <= '0;
            bp.perf_mispredicts <= '0;
        end else if (bp.upd_valid) begin
            bp.perf_branches <= bp.perf_branches + 32'd1;
            if (mispredict) bp.perf_mispredicts <= bp.perf_mispredicts + 32'd1;
        end
    end
`endif

    // Word-aligned PCs: the low address bits carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc[1:0], bp.upd_pc[1:0], bp.upd_target[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16, CTR_W=2): directed vector table
// plus hand-written async-reset sequence; perf counters checked when BP_PERF_CNT_EN is defined.
module tb_branch_predictor;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(16), .CTR_W(2)) dut (
        .CLK(clk),
        .RST(rst),
        .bp (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] upn;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_npc;
        logic        e_cor;
        logic        e_wt;
        logic [31:0] e_red;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [31:0] if_pc, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic upt,
                                input logic [31:0] upn, input logic e_hit, input logic e_tk,
                                input logic [31:0] e_npc, input logic e_cor, input logic e_wt,
                                input logic [31:0] e_red);
        vec_t v;
        v.if_pc = if_pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt; v.upn = upn;
        v.e_hit = e_hit; v.e_tk = e_tk; v.e_npc = e_npc; v.e_cor = e_cor; v.e_wt = e_wt; v.e_red = e_red;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bp_if.if_pc          = v.if_pc;
        bp_if.upd_valid      = v.uv;
        bp_if.upd_pc         = v.upc;
        bp_if.upd_taken      = v.ut;
        bp_if.upd_target     = v.utgt;
        bp_if.upd_pred_taken = v.upt;
        bp_if.upd_pred_npc   = v.upn;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //               if_pc         uv upc           ut utgt        upt upn           hit tk npc           cor wt redirect
        vecs[0]  = mk(32'h40,       0, 32'h0,       0, 32'h0,      0, 32'h0,       0, 0, 32'h44,       1, 0, 32'h4);
        vecs[1]  = mk(32'h40,       1, 32'h40,      1, 32'h100,    0, 32'h44,      0, 0, 32'h44,       0, 0, 32'h100);
        vecs[2]  = mk(32'h40,       0, 32'h0,       0, 32'h0,      0, 32'h0,       1, 1, 32'h100,      1, 0, 32'h4);
        vecs[3]  = mk(32'h40,       1, 32'h40,      0, 32'h0,      1, 32'h100,     1, 1, 32'h100,      0, 1, 32'h44);
        vecs[4]  = mk(32'h40,       0, 32'h0,       0, 32'h0,      0, 32'h0,       1, 0, 32'h44,       1, 0, 32'h4);
        vecs[5]  = mk(32'h40,       1, 32'h40,      1, 32'h100,    0, 32'h44,      1, 0, 32'h44,       0, 0, 32'h100);
        vecs[6]  = mk(32'h40,       1, 32'h40,      1, 32'h100,    1, 32'h100,     1, 1, 32'h100,      1, 0, 32'h100);
        vecs[7]  = mk(32'h40,       1, 32'h40,      1, 32'h100,    1, 32'h100,     1, 1, 32'h100,      1, 0, 32'h100);
        vecs[8]  = mk(32'h40,       1, 32'h40,      0, 32'h0,      1, 32'h100,     1, 1, 32'h100,      0, 1, 32'h44);
        vecs[9]  = mk(32'h40,       0, 32'h0,       0, 32'h0,      0, 32'h0,       1, 1, 32'h100,      1, 0, 32'h4);
        vecs[10] = mk(32'h40,       1, 32'h40,      0, 32'h0,      1, 32'h100,     1, 1, 32'h100,      0, 1, 32'h44);
        vecs[11] = mk(32'h40,       0, 32'h0,       0, 32'h0,      0, 32'h0,       1, 0, 32'h44,       1, 0, 32'h4);
        vecs[12] = mk(32'h40,       1, 32'h40,      0, 32'h0,      0, 32'h44,      1, 0, 32'h44,       1, 0, 32'h44);
        vecs[13] = mk(32'h40,       1, 32'h40,      0, 32'h0,      0, 32'h44,      1, 0, 32'h44,       1, 0, 32'h44);
        vecs[14] = mk(32'h40,       1, 32'h40,      1, 32'h100,    0, 32'h44,      1, 0, 32'h44,       0, 0, 32'h100);
        vecs[15] = mk(32'h40,       0, 32'h0,       0, 32'h0,      0, 32'h0,       1, 0, 32'h44,       1, 0, 32'h4);
        vecs[16] = mk(32'h80,       1, 32'h80,      1, 32'h300,    0, 32'h84,      0, 0, 32'h84,       0, 0, 32'h300);
        vecs[17] = mk(32'h40,       0, 32'h0,       0, 32'h0,      0, 32'h0,       0, 0, 32'h44,       1, 0, 32'h4);
        vecs[18] = mk(32'h80,       0, 32'h0,       0, 32'h0,      0, 32'h0,       1, 1, 32'h300,      1, 0, 32'h4);
        vecs[19] = mk(32'h80,       1, 32'h80,      1, 32'h500,    1, 32'h300,     1, 1, 32'h300,      0, 0, 32'h500);
        vecs[20] = mk(32'h80,       0, 32'h0,       0, 32'h0,      0, 32'h0,       1, 1, 32'h500,      1, 0, 32'h4);
        vecs[21] = mk(32'h80,       1, 32'h80,      1, 32'h200,    1, 32'h100,     1, 1, 32'h500,      0, 0, 32'h200);
        vecs[22] = mk(32'hC4,       1, 32'hC4,      0, 32'h0,      0, 32'hC8,      0, 0, 32'hC8,       1, 0, 32'hC8);
        vecs[23] = mk(32'hC4,       0, 32'h0,       0, 32'h0,      0, 32'h0,       0, 0, 32'hC8,       1, 0, 32'h4);
        vecs[24] = mk(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 32'h10,    0, 32'h0,       0, 0, 32'h0,        0, 0, 32'h10);
        vecs[25] = mk(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,     1, 32'h10,      1, 1, 32'h10,       0, 1, 32'h0);
        vecs[26] = mk(32'hFFFFFFFC, 0, 32'hC4,      1, 32'h700,    0, 32'h0,       1, 0, 32'h0,        1, 0, 32'h700);
        vecs[27] = mk(32'hC4,       0, 32'h0,       0, 32'h0,      0, 32'h0,       0, 0, 32'hC8,       1, 0, 32'h4);

        // Reset state, sampled while RST is still high.
        rst = 1'b1;
        drive(vecs[0]);
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst hit", bp_if.pred_hit, 1'b0);
        check("rst taken", bp_if.pred_taken, 1'b0);
        check("rst npc", bp_if.pred_npc, 32'h44);
        check("rst correct", bp_if.btb_correct, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check($sformatf("v%0d hit", i), bp_if.pred_hit, vecs[i].e_hit);
            check($sformatf("v%0d taken", i), bp_if.pred_taken, vecs[i].e_tk);
            check($sformatf("v%0d npc", i), bp_if.pred_npc, vecs[i].e_npc);
            check($sformatf("v%0d correct", i), bp_if.btb_correct, vecs[i].e_cor);
            check($sformatf("v%0d wrongtype", i), bp_if.btb_wrongtype, vecs[i].e_wt);
            check($sformatf("v%0d redirect", i), bp_if.redirect_pc, vecs[i].e_red);
        end

`ifdef BP_PERF_CNT_EN
        @(negedge clk);
        #2;
        check("perf branches", bp_if.perf_branches, 32'd16);
        check("perf mispredicts", bp_if.perf_mispredicts, 32'd11);
`endif

        // Async reset mid-cycle with an update pending: table clears at once, update dropped.
        @(negedge clk);
        drive(mk(32'h80, 1, 32'h40, 1, 32'h900, 0, 32'h44, 0, 0, 0, 0, 0, 0));
        #2;
        check("pre-rst hit 0x80", bp_if.pred_hit, 1'b1);
        check("pre-rst npc 0x80", bp_if.pred_npc, 32'h200);
        #1 rst = 1'b1;
        #1;
        check("async rst hit", bp_if.pred_hit, 1'b0);
        check("async rst taken", bp_if.pred_taken, 1'b0);
        check("async rst npc", bp_if.pred_npc, 32'h84);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        #2;
        check("post-rst hit 0x40", bp_if.pred_hit, 1'b0);
        check("post-rst npc 0x40", bp_if.pred_npc, 32'h44);
        bp_if.if_pc = 32'hFFFFFFFC;
        #1;
        check("post-rst hit top", bp_if.pred_hit, 1'b0);
        check("post-rst npc top", bp_if.pred_npc, 32'h0);
`ifdef BP_PERF_CNT_EN
        check("post-rst perf branches", bp_if.perf_branches, 32'd0);
        check("post-rst perf mispredicts", bp_if.perf_mispredicts, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
